pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents: controller state encoding, performance counter width,
// memory-wait timeout limit, register-zero index and a saturating
// increment helper for the 16-bit counters.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam int          CNT_W         = 16;
  localparam int          WAIT_W        = 8;
  localparam int          REG_W         = 5;
  localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;
  localparam logic [4:0]  REG_ZERO      = 5'd0;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-facing bundle of the hazard controller.
// Inputs to the controller: ID source fields, ID/EX load info, EX branch
// status and the data-memory busy flag. Outputs from the controller: the
// five stage load enables and the two bubble-insert flushes.
// Signalling: every field is level-sensitive and valid in every cycle;
// there is no handshake. The controller answers in the same cycle
// (combinational), and the pipeline samples the enables/flushes on the
// next rising clock edge.
//   master : pipeline side (drives hazard inputs, receives controls)
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch;
  logic             ex_zero;
  logic             mem_busy;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             if_id_flush;
  logic             id_ex_flush;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch, ex_zero, mem_busy,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           mem_wb_write, if_id_flush, id_ex_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch, ex_zero, mem_busy,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           mem_wb_write, if_id_flush, id_ex_flush
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   mem_read, ex_rt : load flag and destination of the instruction in EX
//   id_rs, id_rt    : source fields of the instruction in ID
//   uses_rt         : ID instruction actually reads rt
//   hazard          : ID needs a value the EX load has not produced yet
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             uses_rt,
  output logic             hazard
);

  // Register zero is hardwired, so a load into it never creates a dependency.
  assign hazard = mem_read && (ex_rt != REG_ZERO) &&
                  ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls on load-use, flushes on taken
// branches, freezes the whole pipe while data memory is busy, and keeps
// saturating performance counters plus a sticky memory-timeout flag.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : pipeline bundle (slave side)
//   stall_cycles : cycles with pc_write low (saturating)
//   flush_events : taken-branch flushes (saturating)
//   mem_timeout  : sticky, set after 255 consecutive waiting cycles
//   state_dbg    : current controller state
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events,
  output logic              mem_timeout,
  output state_t            state_dbg
);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              lu_hazard;
  logic              br_taken;
  logic              flush_now;

  load_use_detect u_detect (
    .mem_read (bus.ex_mem_read),
    .ex_rt    (bus.ex_rt),
    .id_rs    (bus.id_rs),
    .id_rt    (bus.id_rt),
    .uses_rt  (bus.id_uses_rt),
    .hazard   (lu_hazard)
  );

  assign br_taken  = bus.ex_branch && bus.ex_zero;
  assign state_dbg = state;

  // Every state re-evaluates events from scratch; the state only changes
  // what is ignored (load-use right after a branch flush, since ID then
  // holds a bubble).
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.id_ex_write  = 1'b1;
    bus.ex_mem_write = 1'b1;
    bus.mem_wb_write = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    next_state       = RUN;
    flush_now        = 1'b0;

    if (rst) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_write  = 1'b0;
      bus.ex_mem_write = 1'b0;
      bus.mem_wb_write = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
    end else if (bus.mem_busy) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_write  = 1'b0;
      bus.ex_mem_write = 1'b0;
      bus.mem_wb_write = 1'b0;
      next_state       = MEM_WAIT;
    end else if (br_taken) begin
      // PC keeps loading (branch target); the wrong-path instructions in
      // IF/ID and ID/EX are replaced by bubbles.
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      next_state       = BR_FLUSH;
      flush_now        = 1'b1;
    end else if (lu_hazard && (state != BR_FLUSH)) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_flush  = 1'b1;
      next_state       = LOAD_STALL;
    end
  end

  // The wait counter tracks cycles spent in MEM_WAIT with memory still busy;
  // the first busy cycle (the one entering MEM_WAIT) is not counted.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (next_state != MEM_WAIT) begin
      wait_cnt_next = '0;
    end else if ((state == MEM_WAIT) && (wait_cnt != TIMEOUT_LIMIT)) begin
      wait_cnt_next = wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      stall_cycles <= '0;
      flush_events <= '0;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      if (!bus.pc_write) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      if (flush_now) begin
        flush_events <= sat_inc(flush_events);
      end
      if (wait_cnt_next == TIMEOUT_LIMIT) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_branch;
    logic       ex_zero;
    logic       mem_busy;
  } stim_t;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush,
  //  stall_cycles, flush_events, mem_timeout}
  localparam int W = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
  logic        mem_timeout;
  state_t      state_dbg;

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .mem_timeout  (mem_timeout),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Reference model state: plain totals and run lengths.
  int m_stall   = 0;
  int m_flush   = 0;
  int m_run     = 0;
  bit m_timeout = 1'b0;
  bit m_prev_br = 1'b0;

  // ---------------- driver ----------------
  task automatic step(input stim_t s);
    logic [4:0] en;
    logic [1:0] fl;
    bit br, lu;
    @(posedge clk);
    #1;
    rst             = s.rst;
    bus.id_rs       = s.id_rs;
    bus.id_rt       = s.id_rt;
    bus.id_uses_rt  = s.id_uses_rt;
    bus.ex_mem_read = s.ex_mem_read;
    bus.ex_rt       = s.ex_rt;
    bus.ex_branch   = s.ex_branch;
    bus.ex_zero     = s.ex_zero;
    bus.mem_busy    = s.mem_busy;

    br = s.ex_branch && s.ex_zero;
    lu = s.ex_mem_read && (s.ex_rt != 5'd0) &&
         ((s.ex_rt == s.id_rs) || (s.id_uses_rt && (s.ex_rt == s.id_rt)));

    if (s.rst) begin
      en = 5'b00000; fl = 2'b11;
    end else if (s.mem_busy) begin
      en = 5'b00000; fl = 2'b00;
    end else if (br) begin
      en = 5'b11111; fl = 2'b11;
    end else if (lu && !m_prev_br) begin
      en = 5'b00111; fl = 2'b01;
    end else begin
      en = 5'b11111; fl = 2'b00;
    end
    exp_q.push_back({en, fl, 16'(m_stall), 16'(m_flush), m_timeout});

    if (s.rst) begin
      m_stall = 0; m_flush = 0; m_run = 0; m_timeout = 0; m_prev_br = 0;
    end else begin
      if (!en[4]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (!s.mem_busy && br) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      m_run = s.mem_busy ? m_run + 1 : 0;
      if (m_run >= 256) m_timeout = 1'b1;
      m_prev_br = !s.mem_busy && br;
    end
  endtask

  function automatic stim_t mk(input bit r, input int rs, input int rt,
                               input bit uses, input bit mr, input int ert,
                               input bit b, input bit z, input bit busy);
    stim_t s;
    s.rst = r; s.id_rs = 5'(rs); s.id_rt = 5'(rt); s.id_uses_rt = uses;
    s.ex_mem_read = mr; s.ex_rt = 5'(ert); s.ex_branch = b; s.ex_zero = z;
    s.mem_busy = busy;
    return s;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(0, 1, 2, 1, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic busy_run(input int n);
    for (int i = 0; i < n; i++) step(mk(0, 3, 4, 1, 1, 3, 1, 1, 1));
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst         = ($urandom_range(0, 63) == 0);
    s.id_rs       = 5'($urandom_range(0, 3));
    s.id_rt       = 5'($urandom_range(0, 3));
    s.id_uses_rt  = 1'($urandom_range(0, 1));
    s.ex_mem_read = 1'($urandom_range(0, 1));
    s.ex_rt       = 5'($urandom_range(0, 3));
    s.ex_branch   = ($urandom_range(0, 3) == 0);
    s.ex_zero     = 1'($urandom_range(0, 1));
    s.mem_busy    = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] act, exp_v;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {bus.pc_write, bus.if_id_write, bus.id_ex_write,
               bus.ex_mem_write, bus.mem_wb_write,
               bus.if_id_flush, bus.id_ex_flush,
               stall_cycles, flush_events, mem_timeout};
        n_tests++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: en/fl got %b need %b, stall got %h need %h, flush got %h need %h, timeout got %b need %b",
                   cyc_no, act[39:33], exp_v[39:33], act[32:17], exp_v[32:17],
                   act[16:1], exp_v[16:1], act[0], exp_v[0]);
        end
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    int guard;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rt = '0; bus.ex_branch = 1'b0;
    bus.ex_zero = 1'b0; bus.mem_busy = 1'b0;

    do_reset(3);

    // load-use stall, then back to RUN with one stall counted
    step(mk(0, 5, 7, 0, 1, 5, 0, 0, 0));
    idle(2);

    // load into register zero never stalls
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    idle(1);

    // load-use via rt, then load-use right after a branch flush is ignored
    do_reset(1);
    step(mk(0, 9, 6, 1, 1, 6, 0, 0, 0));
    step(mk(0, 9, 6, 0, 1, 6, 0, 0, 0));
    step(mk(0, 1, 1, 0, 0, 0, 1, 1, 0));
    step(mk(0, 4, 4, 1, 1, 4, 0, 0, 0));
    step(mk(0, 4, 4, 1, 1, 4, 0, 0, 0));

    // branch taken with simultaneous load-use
    do_reset(1);
    step(mk(0, 5, 5, 1, 1, 5, 1, 1, 0));
    idle(2);

    // 3-cycle memory wait, with a frozen branch resolving on release
    do_reset(1);
    busy_run(3);
    step(mk(0, 2, 2, 0, 0, 0, 1, 1, 0));
    idle(2);

    // reset in the middle of a stall and of a wait
    step(mk(0, 8, 0, 0, 1, 8, 0, 0, 0));
    do_reset(1);
    idle(1);
    busy_run(5);
    do_reset(1);
    idle(2);

    // 255 busy cycles: no timeout; 256 busy cycles: timeout, sticky
    busy_run(255);
    idle(3);
    do_reset(1);
    busy_run(256);
    idle(4);
    do_reset(1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) step(rand_stim());

    // counter saturation
    do_reset(1);
    busy_run(65540);
    idle(3);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
